// File: rtl/tdt_dm_hs_rcv_pkg.sv
// Shared definitions for the four-phase handshake receiver: FSM encodings
// and the default synchronizer depth.
package tdt_dm_hs_rcv_pkg;

  localparam int SYNC_NUM_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VALID = 2'b01,
    ST_ACK   = 2'b10
  } hs_state_e;

endpackage

// File: rtl/tdt_dm_hs_rcv_sync_dff.sv
// Multi-flop level synchronizer bringing an asynchronous signal into clk.
module tdt_dm_sync_dff #(
  parameter int SYNC_NUM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_NUM-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_NUM-2:0], d};
  end

  assign q = chain[SYNC_NUM-1];

endmodule

// File: rtl/tdt_dm_hs_rcv.sv
// Four-phase handshake receiver: synchronizes src_req, captures the bundled
// payload, presents it as valid/ready, and returns the acknowledge level.
module tdt_dm_hs_rcv
  import tdt_dm_hs_rcv_pkg::*;
#(
  parameter int SYNC_NUM   = SYNC_NUM_DEFAULT,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  dst_clk,
  input  logic                  dst_rst,
  input  logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  dst_ack,
  output logic                  dst_vld,
  output logic [DATA_WIDTH-1:0] dst_data,
  input  logic                  dst_rdy,
  output logic                  dst_busy
);

  logic      req_s;
  hs_state_e state;

  tdt_dm_sync_dff #(
    .SYNC_NUM(SYNC_NUM)
  ) u_req_sync (
    .clk(dst_clk),
    .rst(dst_rst),
    .d  (src_req),
    .q  (req_s)
  );

  // Outputs are updated alongside the state so every one of them is a flop.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      state    <= ST_IDLE;
      dst_ack  <= 1'b0;
      dst_vld  <= 1'b0;
      dst_busy <= 1'b0;
      dst_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_s) begin
            dst_data <= src_data;
            dst_vld  <= 1'b1;
            dst_busy <= 1'b1;
            state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          // A request drop here is a sender violation; still wait for the consumer.
          if (dst_rdy) begin
            dst_vld <= 1'b0;
            dst_ack <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            dst_ack  <= 1'b0;
            dst_busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          dst_ack  <= 1'b0;
          dst_vld  <= 1'b0;
          dst_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdt_dm_hs_rcv.sv
// Self-checking bench for tdt_dm_hs_rcv: payload scoreboard plus per-scenario
// timing checks of vld/ack/busy.
module tb_tdt_dm_hs_rcv;

  localparam int SN = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_req;
  logic [DW-1:0] src_data;
  logic          dst_ack;
  logic          dst_vld;
  logic [DW-1:0] dst_data;
  logic          dst_rdy;
  logic          dst_busy;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  tdt_dm_hs_rcv #(
    .SYNC_NUM  (SN),
    .DATA_WIDTH(DW)
  ) dut (
    .dst_clk (clk),
    .dst_rst (rst),
    .src_req (src_req),
    .src_data(src_data),
    .dst_ack (dst_ack),
    .dst_vld (dst_vld),
    .dst_data(dst_data),
    .dst_rdy (dst_rdy),
    .dst_busy(dst_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: vld&rdy seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst === 1'b0 && dst_vld === 1'b1 && dst_rdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL handshake_unexpected: got data=%h, expected no transfer", dst_data);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (dst_data !== exp) begin
          errors++;
          $display("FAIL handshake_data: got %h, expected %h", dst_data, exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; src_req = 1'b1; src_data = 32'hFFFF_FFFF; dst_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({dst_ack, dst_vld, dst_busy} !== 3'b000 || dst_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: got ack/vld/busy=%b data=%h, expected 000 data=0",
                 {dst_ack, dst_vld, dst_busy}, dst_data);
      end
    end
    src_req = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({dst_ack, dst_vld, dst_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got ack/vld/busy=%b, expected 000", {dst_ack, dst_vld, dst_busy});
    end
  endtask

  task automatic test_idle_rdy();
    dst_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({dst_ack, dst_vld, dst_busy} !== 3'b000 || dst_data !== '0) begin
        errors++;
        $display("FAIL idle_rdy: got ack/vld/busy=%b data=%h, expected 000 data=0",
                 {dst_ack, dst_vld, dst_busy}, dst_data);
      end
    end
  endtask

  task automatic test_basic();
    dst_rdy = 1'b1;
    src_data = 32'hA5A5_0001;
    sb.push_back(src_data);
    src_req = 1'b1;
    for (int e = 1; e <= SN + 1; e++) begin
      tick();
      checks++;
      if (e <= SN && dst_vld !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_vld: edge %0d got vld=%b, expected 0", e, dst_vld);
      end else if (e == SN + 1 && (dst_vld !== 1'b1 || dst_data !== 32'hA5A5_0001 || dst_busy !== 1'b1)) begin
        errors++;
        $display("FAIL basic_vld: got vld=%b data=%h busy=%b, expected 1 a5a50001 1",
                 dst_vld, dst_data, dst_busy);
      end
    end
    tick();
    checks++;
    if (dst_ack !== 1'b1 || dst_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got ack=%b vld=%b, expected 1 0", dst_ack, dst_vld);
    end
    tick(); tick();
    src_req = 1'b0;
    for (int e = 1; e <= SN + 1; e++) begin
      tick();
      checks++;
      if (e <= SN && dst_ack !== 1'b1) begin
        errors++;
        $display("FAIL basic_ack_hold: edge %0d got ack=%b, expected 1", e, dst_ack);
      end else if (e == SN + 1 && (dst_ack !== 1'b0 || dst_busy !== 1'b0 || dst_data !== 32'hA5A5_0001)) begin
        errors++;
        $display("FAIL basic_ack_drop: got ack=%b busy=%b data=%h, expected 0 0 a5a50001",
                 dst_ack, dst_busy, dst_data);
      end
    end
  endtask

  task automatic test_backpressure();
    dst_rdy = 1'b0;
    src_data = 32'h0BAD_F00D;
    sb.push_back(src_data);
    src_req = 1'b1;
    for (int n = 0; n < 10 && dst_vld !== 1'b1; n++) tick();
    checks++;
    if (dst_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_vld_timeout: got vld=%b, expected 1", dst_vld);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dst_vld !== 1'b1 || dst_data !== 32'h0BAD_F00D || dst_ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall: got vld=%b data=%h ack=%b, expected 1 0badf00d 0",
                 dst_vld, dst_data, dst_ack);
      end
    end
    dst_rdy = 1'b1;
    tick();
    checks++;
    if (dst_ack !== 1'b1 || dst_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack: got ack=%b vld=%b, expected 1 0", dst_ack, dst_vld);
    end
    src_req = 1'b0;
    for (int n = 0; n < 10 && dst_ack !== 1'b0; n++) tick();
    checks++;
    if (dst_ack !== 1'b0 || dst_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack_drop: got ack=%b busy=%b, expected 0 0", dst_ack, dst_busy);
    end
  endtask

  task automatic test_back_to_back();
    dst_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data = DW'(i);
      sb.push_back(src_data);
      src_req = 1'b1;
      for (int n = 0; n < 20 && dst_ack !== 1'b1; n++) tick();
      checks++;
      if (dst_ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ack_timeout: transfer %0d got ack=%b, expected 1", i, dst_ack);
      end
      src_req = 1'b0;
      src_data = 32'hDEAD_BEEF;
      for (int n = 0; n < 20 && dst_ack !== 1'b0; n++) tick();
      checks++;
      if (dst_ack !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ack_drop_timeout: transfer %0d got ack=%b, expected 0", i, dst_ack);
      end
    end
    tick(); tick();
    checks++;
    if (sb.size() != 0 || dst_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got pending=%0d busy=%b, expected 0 0", sb.size(), dst_busy);
    end
  endtask

  task automatic test_reset_mid_ack();
    dst_rdy = 1'b1;
    src_data = 32'hC0DE_0035;
    sb.push_back(src_data);
    src_req = 1'b1;
    for (int n = 0; n < 20 && dst_ack !== 1'b1; n++) tick();
    checks++;
    if (dst_ack !== 1'b1) begin
      errors++;
      $display("FAIL rma_ack_timeout: got ack=%b, expected 1", dst_ack);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dst_ack, dst_vld, dst_busy} !== 3'b000 || dst_data !== '0) begin
      errors++;
      $display("FAIL rma_reset: got ack/vld/busy=%b data=%h, expected 000 data=0",
               {dst_ack, dst_vld, dst_busy}, dst_data);
    end
    sb.push_back(32'hC0DE_0035);
    for (int e = 1; e <= SN + 1; e++) begin
      tick();
      checks++;
      if (e <= SN && dst_vld !== 1'b0) begin
        errors++;
        $display("FAIL rma_early_vld: edge %0d got vld=%b, expected 0", e, dst_vld);
      end else if (e == SN + 1 && (dst_vld !== 1'b1 || dst_data !== 32'hC0DE_0035)) begin
        errors++;
        $display("FAIL rma_redeliver: got vld=%b data=%h, expected 1 c0de0035", dst_vld, dst_data);
      end
    end
    tick();
    src_req = 1'b0;
    for (int n = 0; n < 20 && dst_busy !== 1'b0; n++) tick();
    checks++;
    if (dst_busy !== 1'b0 || dst_ack !== 1'b0) begin
      errors++;
      $display("FAIL rma_finish: got busy=%b ack=%b, expected 0 0", dst_busy, dst_ack);
    end
  endtask

  task automatic test_early_drop();
    dst_rdy = 1'b0;
    src_data = 32'h1234_5678;
    sb.push_back(src_data);
    src_req = 1'b1;
    for (int n = 0; n < 10 && dst_vld !== 1'b1; n++) tick();
    src_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dst_vld !== 1'b1 || dst_ack !== 1'b0 || dst_busy !== 1'b1 || dst_data !== 32'h1234_5678) begin
        errors++;
        $display("FAIL drop_hold: got vld=%b ack=%b busy=%b data=%h, expected 1 0 1 12345678",
                 dst_vld, dst_ack, dst_busy, dst_data);
      end
    end
    dst_rdy = 1'b1;
    tick();
    checks++;
    if (dst_ack !== 1'b1 || dst_vld !== 1'b0) begin
      errors++;
      $display("FAIL drop_ack: got ack=%b vld=%b, expected 1 0", dst_ack, dst_vld);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({dst_ack, dst_vld, dst_busy} !== 3'b000) begin
        errors++;
        $display("FAIL drop_idle: cycle %0d got ack/vld/busy=%b, expected 000", i, {dst_ack, dst_vld, dst_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_rdy();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_ack();
    test_early_drop();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
